inst_fetch_buffer: RTL and testbench

- Decoupling queue between the IF stage and the ID stage.
- Captures each valid {inst, pc} bundle that IF presents and replays the bundles to ID in program order, so IF keeps fetching while ID stalls.
- Supplies the `ds_allowin` back-pressure that IF consumes, so IF is unchanged and sees this block as its downstream stage.
- Drops all queued entries on a pipeline flush (exception/ertn from WB) or on a taken branch resolved in ID.

---
 rtl/inst_fetch_buffer_pkg.sv | 12 +
 rtl/inst_fetch_buffer_ram.sv | 43 ++++
 rtl/inst_fetch_buffer.sv | 96 +++++++++
 tb/tb_inst_fetch_buffer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_buffer_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer_pkg
// Shared constants for the IF->ID fetch buffer.
//   FS_TO_DS_BUS_WD : width of the {inst[31:0], pc[31:0]} bundle from IF
//   FB_DEPTH        : default number of buffer entries (power of two, >= 2)
// ---------------------------------------------------------------------------
package inst_fetch_buffer_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int FB_DEPTH        = 4;

endpackage : inst_fetch_buffer_pkg

// File: rtl/inst_fetch_buffer_ram.sv
// ---------------------------------------------------------------------------
// fb_entry_ram
// DEPTH x BUS_WD register array backing the fetch buffer.
// Ports:
//   clk    in   write clock (rising edge)
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  read data (asynchronous, combinational from raddr)
// The storage is deliberately not reset; validity is tracked by the owner.
// ---------------------------------------------------------------------------
module fb_entry_ram
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH  = FB_DEPTH,
    parameter int BUS_WD = FS_TO_DS_BUS_WD,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [BUS_WD-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [BUS_WD-1:0] rdata
);

    logic [BUS_WD-1:0] mem_q [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (we && (waddr == AW'(gi))) begin
                    mem_q[gi] <= wdata;
                end
            end
        end
    endgenerate

    assign rdata = mem_q[raddr];

endmodule : fb_entry_ram

// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
// Decoupling FIFO between IF and ID. IF sees this block as its downstream
// stage (fb_allowin drives IF's ds_allowin); ID sees it as its upstream.
// Ports:
//   clk, resetn        clock / asynchronous active-low reset
//   fs_to_ds_valid/bus bundle presented by IF
//   fb_allowin         buffer can accept a bundle this cycle
//   fb_to_ds_valid/bus head bundle offered to ID
//   ds_allowin         ID accepts the head this cycle
//   br_cancel          taken branch in ID, queued entries are wrong-path
//   fs_flush_pipe      exception/ertn flush from WB
//   fb_count           current occupancy
// ---------------------------------------------------------------------------
module inst_fetch_buffer
    import inst_fetch_buffer_pkg::*;
#(
    parameter int DEPTH  = FB_DEPTH,
    parameter int BUS_WD = FS_TO_DS_BUS_WD
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       fs_to_ds_valid,
    input  logic [BUS_WD-1:0]          fs_to_ds_bus,
    output logic                       fb_allowin,
    output logic                       fb_to_ds_valid,
    output logic [BUS_WD-1:0]          fb_to_ds_bus,
    input  logic                       ds_allowin,
    input  logic                       br_cancel,
    input  logic                       fs_flush_pipe,
    output logic [$clog2(DEPTH+1)-1:0] fb_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [PTR_W-1:0]  wp_q, wp_d;
    logic [PTR_W-1:0]  rp_q, rp_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              kill, push, pop, not_empty;
    logic [BUS_WD-1:0] head_data;

    assign kill       = br_cancel | fs_flush_pipe;
    assign not_empty  = (count_q != '0);
    // Derived from registered occupancy only, so IF never sees a
    // combinational path from ID's ds_allowin.
    assign fb_allowin     = (count_q != CNT_W'(DEPTH));
    assign fb_to_ds_valid = not_empty & ~kill;
    assign push           = fs_to_ds_valid & fb_allowin & ~kill;
    assign pop            = fb_to_ds_valid & ds_allowin;

    // Mask the bus while empty so ID never sees a stale entry.
    assign fb_to_ds_bus = not_empty ? head_data : '0;
    assign fb_count     = count_q;

    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (kill) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) wp_d = wp_q + PTR_W'(1);
            if (pop)  rp_d = rp_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    fb_entry_ram #(
        .DEPTH  (DEPTH),
        .BUS_WD (BUS_WD),
        .AW     (PTR_W)
    ) u_fb_entry_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wp_q),
        .wdata (fs_to_ds_bus),
        .raddr (rp_q),
        .rdata (head_data)
    );

endmodule : inst_fetch_buffer

// File: tb/tb_inst_fetch_buffer.sv
module tb_inst_fetch_buffer;

    localparam int DEPTH  = 4;
    localparam int BUS_WD = 64;

    logic              clk;
    logic              resetn;
    logic              fs_to_ds_valid;
    logic [BUS_WD-1:0] fs_to_ds_bus;
    logic              fb_allowin;
    logic              fb_to_ds_valid;
    logic [BUS_WD-1:0] fb_to_ds_bus;
    logic              ds_allowin;
    logic              br_cancel;
    logic              fs_flush_pipe;
    logic [2:0]        fb_count;

    int tests_run = 0;
    int tests_failed = 0;

    inst_fetch_buffer #(.DEPTH(DEPTH), .BUS_WD(BUS_WD)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .fs_to_ds_valid (fs_to_ds_valid),
        .fs_to_ds_bus   (fs_to_ds_bus),
        .fb_allowin     (fb_allowin),
        .fb_to_ds_valid (fb_to_ds_valid),
        .fb_to_ds_bus   (fb_to_ds_bus),
        .ds_allowin     (ds_allowin),
        .br_cancel      (br_cancel),
        .fs_flush_pipe  (fs_flush_pipe),
        .fb_count       (fb_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bundle carried for a pc: instruction word derived from the pc.
    function automatic logic [63:0] mk_bus(input logic [31:0] pc);
        return {pc ^ 32'hA5A5_0000, pc};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: program-order queue of bundles plus a log of the
    // pcs actually handed to ID. Inputs are stable from posedge+1 to the
    // next posedge, so the negedge sees exactly what the next edge uses.
    // ------------------------------------------------------------------
    logic [63:0] mq[$];
    logic [31:0] dlv[$];

    always @(negedge clk) begin
        logic        e_allow, e_valid, kill, do_push, do_pop;
        logic [63:0] e_bus;
        logic [31:0] e_cnt;
        if (!resetn) begin
            mq.delete();
            chk("cyc_rst_valid", 64'(fb_to_ds_valid), 64'd0);
            chk("cyc_rst_bus",   fb_to_ds_bus,        64'd0);
            chk("cyc_rst_allow", 64'(fb_allowin),     64'd1);
            chk("cyc_rst_count", 64'(fb_count),       64'd0);
        end else begin
            kill    = br_cancel || fs_flush_pipe;
            e_cnt   = mq.size();
            e_allow = (mq.size() < DEPTH);
            e_valid = (mq.size() > 0) && !kill;
            e_bus   = (mq.size() > 0) ? mq[0] : 64'd0;
            chk("cyc_allowin", 64'(fb_allowin),     64'(e_allow));
            chk("cyc_valid",   64'(fb_to_ds_valid), 64'(e_valid));
            chk("cyc_bus",     fb_to_ds_bus,        e_bus);
            chk("cyc_count",   64'(fb_count),       64'(e_cnt));
            do_pop  = e_valid && ds_allowin;
            do_push = fs_to_ds_valid && e_allow && !kill;
            if (kill) begin
                mq.delete();
            end else begin
                if (do_pop) begin
                    logic [63:0] h;
                    h = mq.pop_front();
                    dlv.push_back(h[31:0]);
                end
                if (do_push) mq.push_back(fs_to_ds_bus);
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers: drive at posedge+1, then advance one cycle.
    // ------------------------------------------------------------------
    task automatic drive(input logic v, input logic [31:0] pc, input logic ds,
                         input logic br, input logic fl);
        fs_to_ds_valid = v;
        fs_to_ds_bus   = v ? mk_bus(pc) : 64'd0;
        ds_allowin     = ds;
        br_cancel      = br;
        fs_flush_pipe  = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic v, input logic [31:0] pc, input logic ds);
        drive(v, pc, ds, 1'b0, 1'b0);
        tick();
    endtask

    task automatic idle_drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1);
    endtask

    initial begin
        resetn = 1'b0;
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("reset_count", 64'(fb_count), 64'd0);
        chk("reset_allowin", 64'(fb_allowin), 64'd1);
        chk("reset_valid", 64'(fb_to_ds_valid), 64'd0);
        tick();
        tick();
        resetn = 1'b1;

        // ---------------- fill and drain ----------------
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1c000000 + 32'(4*i), 1'b0);
        chk("fill_count", 64'(fb_count), 64'd4);
        chk("fill_allowin", 64'(fb_allowin), 64'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 1'b1);
        chk("drain_valid", 64'(fb_to_ds_valid), 64'd0);
        chk("drain_num", 64'(dlv.size()), 64'd4);
        for (int i = 0; i < 4 && i < dlv.size(); i++)
            chk("drain_order", 64'(dlv[i]), 64'(32'h1c000000 + 32'(4*i)));
        dlv.delete();

        // ---------------- concurrent push/pop with wrap ----------------
        step(1'b1, 32'h1c000200, 1'b0);
        step(1'b1, 32'h1c000204, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h1c000208 + 32'(4*i), 1'b1);
            chk("conc_count", 64'(fb_count), 64'd2);
        end
        idle_drain(3);
        chk("conc_num", 64'(dlv.size()), 64'd12);
        for (int i = 0; i < 12 && i < dlv.size(); i++)
            chk("conc_order", 64'(dlv[i]), 64'(32'h1c000200 + 32'(4*i)));
        dlv.delete();

        // ---------------- full with pop ----------------
        for (int i = 0; i < 4; i++) step(1'b1, 32'h1c000300 + 32'(4*i), 1'b0);
        step(1'b1, 32'h1c000310, 1'b1);        // full: pop only
        chk("fullpop_count", 64'(fb_count), 64'd3);
        chk("fullpop_allowin", 64'(fb_allowin), 64'd1);
        step(1'b1, 32'h1c000310, 1'b0);        // accepted now
        chk("fullpop_refill", 64'(fb_count), 64'd4);
        idle_drain(5);
        chk("fullpop_num", 64'(dlv.size()), 64'd5);
        for (int i = 0; i < 5 && i < dlv.size(); i++)
            chk("fullpop_order", 64'(dlv[i]), 64'(32'h1c000300 + 32'(4*i)));
        dlv.delete();

        // ---------------- flush ----------------
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1c000400 + 32'(4*i), 1'b0);
        drive(1'b1, 32'h1c000020, 1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_valid_now", 64'(fb_to_ds_valid), 64'd0);
        tick();
        chk("flush_count", 64'(fb_count), 64'd0);
        chk("flush_bus", fb_to_ds_bus, 64'd0);
        idle_drain(3);
        chk("flush_none", 64'(dlv.size()), 64'd0);
        dlv.delete();

        // ---------------- branch cancel ----------------
        step(1'b1, 32'h1c000500, 1'b0);
        step(1'b1, 32'h1c000504, 1'b0);
        drive(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
        tick();
        step(1'b1, 32'h1c000100, 1'b0);        // push right after kill
        chk("br_head_valid", 64'(fb_to_ds_valid), 64'd1);
        chk("br_head_pc", 64'(fb_to_ds_bus[31:0]), 64'h1c000100);
        idle_drain(2);
        chk("br_num", 64'(dlv.size()), 64'd1);
        if (dlv.size() > 0) chk("br_pc", 64'(dlv[0]), 64'h1c000100);
        dlv.delete();

        // ---------------- async reset mid-operation ----------------
        for (int i = 0; i < 3; i++) step(1'b1, 32'h1c000600 + 32'(4*i), 1'b0);
        drive(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
        #1;
        resetn = 1'b0;                           // between edges
        #1;
        chk("arst_count", 64'(fb_count), 64'd0);
        chk("arst_valid", 64'(fb_to_ds_valid), 64'd0);
        chk("arst_bus", fb_to_ds_bus, 64'd0);
        chk("arst_allowin", 64'(fb_allowin), 64'd1);
        tick();
        resetn = 1'b1;
        step(1'b1, 32'h1c000700, 1'b0);
        step(1'b1, 32'h1c000704, 1'b1);
        idle_drain(2);
        chk("arst_num", 64'(dlv.size()), 64'd2);
        if (dlv.size() > 0) chk("arst_first", 64'(dlv[0]), 64'h1c000700);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_inst_fetch_buffer
